oam_dma: RTL and testbench

- CPU-side initiator that drives the PPU register port.
- On a CPU write to $4014 it halts the CPU, then copies 256 bytes from CPU page $XX00–$XXFF into PPU OAM. Each byte is one read from CPU memory followed by one write to PPU register 4 (OAMDATA).
- Sits between the CPU core, CPU work RAM and ppu_core's CPUA/CPUDI/RW/CS inputs, clocked on CPUCLK.

---
 rtl/ppu_pkg.sv | 23 ++
 rtl/oam_dma_if.sv | 27 ++
 rtl/oam_dma.sv | 97 +++++++++
 tb/tb_oam_dma.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU register map, OAM DMA trigger address and the oam_dma state encoding.
package ppu_pkg;

   localparam logic [2:0] PPUCTRL   = 3'd0;
   localparam logic [2:0] PPUMASK   = 3'd1;
   localparam logic [2:0] PPUSTATUS = 3'd2;
   localparam logic [2:0] OAMADDR   = 3'd3;
   localparam logic [2:0] OAMDATA   = 3'd4;
   localparam logic [2:0] PPUSCROLL = 3'd5;
   localparam logic [2:0] PPUADDR   = 3'd6;
   localparam logic [2:0] PPUDATA   = 3'd7;

   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DUMMY,
      ST_ALIGN,
      ST_READ,
      ST_WRITE
   } dma_state_e;

endpackage

// File: rtl/oam_dma_if.sv
// CPU, work-RAM and PPU register-port signals seen by the OAM DMA engine.
interface oam_dma_if;

   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DI;
   logic        CPU_WR;
   logic        DMA_HALT;
   logic        DMA_DONE;
   logic [15:0] MEM_ADDR;
   logic        MEM_RD;
   logic [7:0]  MEM_DI;
   logic [2:0]  PPU_A;
   logic [7:0]  PPU_DO;
   logic        PPU_RW;
   logic        PPU_CS;

   modport master (
      input  CPU_ADDR, CPU_DI, CPU_WR, MEM_DI,
      output DMA_HALT, DMA_DONE, MEM_ADDR, MEM_RD, PPU_A, PPU_DO, PPU_RW, PPU_CS
   );

   modport slave (
      output CPU_ADDR, CPU_DI, CPU_WR, MEM_DI,
      input  DMA_HALT, DMA_DONE, MEM_ADDR, MEM_RD, PPU_A, PPU_DO, PPU_RW, PPU_CS
   );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: on a CPU write to the trigger address, halts the CPU and copies one
// page of CPU memory into PPU OAM through OAMDATA, one read + one write per byte.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = ppu_pkg::DMA_REG_ADDR,
   parameter logic [2:0]  OAMDATA_IDX  = ppu_pkg::OAMDATA,
   parameter int unsigned XFER_LEN     = 256
) (
   input logic        CPUCLK,
   input logic        RST,
   oam_dma_if.master  bus
);

   import ppu_pkg::*;

   localparam int unsigned   CW       = $clog2(XFER_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XFER_LEN - 1);

   dma_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    page_q, page_d;
   logic          cyc_odd_q;

   logic          halt_q;
   logic          done_q;
   logic          mem_rd_q;
   logic [15:0]   mem_addr_q;
   logic          cs_q;
   logic          rw_q;
   logic [2:0]    ppu_a_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      page_d  = page_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.CPU_WR && (bus.CPU_ADDR == DMA_REG_ADDR)) begin
               page_d  = bus.CPU_DI;
               cnt_d   = '0;
               state_d = ST_DUMMY;
            end
         end
         // Parity flips before the next cycle: odd now means even next, so READ can follow directly.
         ST_DUMMY: state_d = cyc_odd_q ? ST_READ : ST_ALIGN;
         ST_ALIGN: state_d = ST_READ;
         ST_READ:  state_d = ST_WRITE;
         ST_WRITE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with state_q.
   always_ff @(posedge CPUCLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         page_q     <= '0;
         cyc_odd_q  <= 1'b0;
         halt_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         cs_q       <= 1'b0;
         rw_q       <= 1'b1;
         ppu_a_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         page_q     <= page_d;
         cyc_odd_q  <= ~cyc_odd_q;
         halt_q     <= (state_d != ST_IDLE);
         done_q     <= (state_q == ST_WRITE) && (state_d == ST_IDLE);
         mem_rd_q   <= (state_d == ST_READ);
         mem_addr_q <= (state_d == ST_READ) ? {page_d, 8'(cnt_d)} : '0;
         cs_q       <= (state_d == ST_WRITE);
         rw_q       <= (state_d != ST_WRITE);
         ppu_a_q    <= (state_d == ST_WRITE) ? OAMDATA_IDX : '0;
      end
   end

   assign bus.DMA_HALT = halt_q;
   assign bus.DMA_DONE = done_q;
   assign bus.MEM_RD   = mem_rd_q;
   assign bus.MEM_ADDR = mem_addr_q;
   assign bus.PPU_CS   = cs_q;
   assign bus.PPU_RW   = rw_q;
   assign bus.PPU_A    = ppu_a_q;
   assign bus.PPU_DO   = cs_q ? bus.MEM_DI : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: timing, data ordering, retrigger, reset, page $FF, back-to-back.
module tb_oam_dma;

   logic CPUCLK = 1'b0;
   logic RST    = 1'b0;
   logic tb_odd;

   oam_dma_if bus();

   oam_dma #(
      .DMA_REG_ADDR(16'h4014),
      .OAMDATA_IDX (3'd4),
      .XFER_LEN    (256)
   ) dut (
      .CPUCLK(CPUCLK),
      .RST   (RST),
      .bus   (bus)
   );

   always #5 CPUCLK = ~CPUCLK;

   // Expected cycle parity, derived independently from reset and the clock.
   always @(posedge CPUCLK) tb_odd <= RST ? ~tb_odd : 1'b0;

   int total = 0;
   int bad   = 0;

   int n_halt, first_halt, last_halt, first_rd, rd_cnt, wr_cnt, wr_bad;
   int addr_bad, seen7, last_wr, done_at, rw_bad, trig_odd;
   logic [15:0] first_addr, last_addr;
   logic [7:0]  exp_page;
   logic [31:0] outs;

   localparam logic [31:0] RESET_OUTS = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 16'd0};

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
   endfunction

   function automatic logic [31:0] pack_outs();
      return {bus.DMA_HALT, bus.DMA_DONE, bus.MEM_RD, bus.PPU_CS, bus.PPU_RW,
              bus.PPU_A, bus.PPU_DO, bus.MEM_ADDR};
   endfunction

   task automatic drive_trigger(input logic [7:0] pg);
      bus.CPU_ADDR = 16'h4014;
      bus.CPU_DI   = pg;
      bus.CPU_WR   = 1'b1;
      exp_page     = pg;
      trig_odd     = int'(tb_odd);
   endtask

   task automatic wait_parity(input logic want);
      for (int k = 0; k < 4; k++) begin
         if (tb_odd == want) break;
         @(negedge CPUCLK);
      end
   endtask

   // Observes one transfer, offset n counted from the trigger cycle T.
   task automatic capture(input int retrig_wr, input int stop_wr);
      n_halt = 0; first_halt = -1; last_halt = -1; first_rd = -1; rd_cnt = 0;
      wr_cnt = 0; wr_bad = 0; addr_bad = 0; seen7 = 0; last_wr = -1;
      done_at = -1; rw_bad = 0; first_addr = 'x; last_addr = 'x;
      for (int n = 1; n <= 600; n++) begin
         @(negedge CPUCLK);
         bus.CPU_WR   = 1'b0;
         bus.CPU_ADDR = 16'h0000;
         if (bus.DMA_HALT) begin
            n_halt++;
            if (first_halt < 0) first_halt = n;
            last_halt = n;
         end
         if (bus.MEM_RD) begin
            if (first_rd < 0) begin
               first_rd   = n;
               first_addr = bus.MEM_ADDR;
            end
            if (bus.MEM_ADDR[15:8] == 8'h07) seen7++;
            if (bus.MEM_ADDR !== {exp_page, 8'(rd_cnt)}) addr_bad++;
            last_addr  = bus.MEM_ADDR;
            bus.MEM_DI = mem_val(bus.MEM_ADDR);
            rd_cnt++;
         end
         if (bus.PPU_CS) begin
            if (bus.PPU_RW !== 1'b0 || bus.PPU_A !== 3'd4 ||
                bus.PPU_DO !== mem_val({exp_page, 8'(wr_cnt)})) wr_bad++;
            last_wr = n;
            wr_cnt++;
            if (wr_cnt - 1 == retrig_wr) begin
               bus.CPU_ADDR = 16'h4014;
               bus.CPU_DI   = 8'h07;
               bus.CPU_WR   = 1'b1;
            end
            if (wr_cnt - 1 == stop_wr) break;
         end else if (bus.PPU_RW !== 1'b1 || bus.PPU_A !== 3'd0) begin
            rw_bad++;
         end
         if (bus.DMA_DONE) begin
            done_at = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (4) @(negedge CPUCLK);
      outs = pack_outs();
      total++;
      if (outs !== RESET_OUTS) begin
         bad++; $display("FAIL reset_outs got=%h want=%h", outs, RESET_OUTS);
      end
      RST = 1'b1;
      @(negedge CPUCLK);
   endtask

   task automatic test_ignore_other_write();
      int h;
      h = 0;
      bus.CPU_ADDR = 16'h4013; bus.CPU_DI = 8'h02; bus.CPU_WR = 1'b1;
      @(negedge CPUCLK);
      bus.CPU_WR = 1'b0; bus.CPU_ADDR = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         if (bus.DMA_HALT || bus.PPU_CS || bus.MEM_RD) h++;
         @(negedge CPUCLK);
      end
      total++;
      if (h !== 0) begin bad++; $display("FAIL ignore_write active=%0d want=0", h); end
   endtask

   task automatic test_even_start();
      wait_parity(1'b0);
      drive_trigger(8'h02);
      capture(-1, -1);
      total++; if (first_halt !== 1) begin bad++; $display("FAIL even_first_halt got=%0d want=1", first_halt); end
      total++; if (first_rd !== 2) begin bad++; $display("FAIL even_first_rd got=%0d want=2", first_rd); end
      total++; if (first_addr !== 16'h0200) begin bad++; $display("FAIL even_first_addr got=%h want=0200", first_addr); end
      total++; if (last_wr !== 513) begin bad++; $display("FAIL even_last_wr got=%0d want=513", last_wr); end
      total++; if (n_halt !== 513 || last_halt !== 513) begin
         bad++; $display("FAIL even_halt got=%0d/%0d want=513/513", n_halt, last_halt); end
      total++; if (wr_cnt !== 256 || wr_bad !== 0) begin
         bad++; $display("FAIL even_writes got=%0d bad=%0d want=256 bad=0", wr_cnt, wr_bad); end
      total++; if (addr_bad !== 0 || rw_bad !== 0) begin
         bad++; $display("FAIL even_addr_rw got=%0d/%0d want=0/0", addr_bad, rw_bad); end
      total++; if (done_at !== 514) begin bad++; $display("FAIL even_done_at got=%0d want=514", done_at); end
      @(negedge CPUCLK);
      total++; if (bus.DMA_DONE !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", bus.DMA_DONE); end
   endtask

   task automatic test_odd_start();
      wait_parity(1'b1);
      drive_trigger(8'h02);
      capture(-1, -1);
      total++; if (first_rd !== 3) begin bad++; $display("FAIL odd_first_rd got=%0d want=3", first_rd); end
      total++; if (n_halt !== 514 || first_halt !== 1) begin
         bad++; $display("FAIL odd_halt got=%0d from=%0d want=514 from=1", n_halt, first_halt); end
      total++; if (last_wr !== 514 || done_at !== 515) begin
         bad++; $display("FAIL odd_end got=%0d/%0d want=514/515", last_wr, done_at); end
      total++; if (wr_cnt !== 256 || wr_bad !== 0 || addr_bad !== 0) begin
         bad++; $display("FAIL odd_data got=%0d bad=%0d abad=%0d want=256/0/0", wr_cnt, wr_bad, addr_bad); end
      @(negedge CPUCLK);
   endtask

   task automatic test_retrigger();
      wait_parity(1'b0);
      drive_trigger(8'h02);
      capture(40, -1);
      total++; if (seen7 !== 0 || addr_bad !== 0) begin
         bad++; $display("FAIL retrig_addr got=%0d/%0d want=0/0", seen7, addr_bad); end
      total++; if (wr_cnt !== 256 || wr_bad !== 0 || done_at !== 514) begin
         bad++; $display("FAIL retrig_xfer got=%0d bad=%0d done=%0d want=256/0/514", wr_cnt, wr_bad, done_at); end
      @(negedge CPUCLK);
   endtask

   task automatic test_reset_mid();
      int cs_after, done_after;
      cs_after = 0; done_after = 0;
      wait_parity(1'b0);
      drive_trigger(8'h02);
      capture(-1, 100);
      total++; if (wr_cnt !== 101) begin bad++; $display("FAIL midrst_reach got=%0d want=101", wr_cnt); end
      RST = 1'b0;
      @(negedge CPUCLK);
      outs = pack_outs();
      total++; if (outs !== RESET_OUTS) begin
         bad++; $display("FAIL midrst_outs got=%h want=%h", outs, RESET_OUTS); end
      RST = 1'b1;
      for (int k = 0; k < 600; k++) begin
         @(negedge CPUCLK);
         if (bus.PPU_CS || bus.DMA_HALT) cs_after++;
         if (bus.DMA_DONE) done_after++;
      end
      total++; if (cs_after !== 0 || done_after !== 0) begin
         bad++; $display("FAIL midrst_after got=%0d/%0d want=0/0", cs_after, done_after); end
   endtask

   task automatic test_page_ff();
      wait_parity(1'b1);
      drive_trigger(8'hFF);
      capture(-1, -1);
      total++; if (last_addr !== 16'hFFFF) begin bad++; $display("FAIL ff_last_addr got=%h want=ffff", last_addr); end
      total++; if (rd_cnt !== 256 || addr_bad !== 0 || wr_bad !== 0) begin
         bad++; $display("FAIL ff_xfer got=%0d abad=%0d wbad=%0d want=256/0/0", rd_cnt, addr_bad, wr_bad); end
      @(negedge CPUCLK);
   endtask

   task automatic test_back_to_back();
      wait_parity(1'b0);
      drive_trigger(8'h02);
      capture(-1, -1);
      total++; if (done_at !== 514) begin bad++; $display("FAIL b2b_first_done got=%0d want=514", done_at); end
      drive_trigger(8'h03);
      capture(-1, -1);
      total++; if (first_halt !== 1 || first_rd !== 2 + trig_odd) begin
         bad++; $display("FAIL b2b_start got=%0d/%0d want=1/%0d", first_halt, first_rd, 2 + trig_odd); end
      total++; if (wr_cnt !== 256 || wr_bad !== 0 || addr_bad !== 0 || done_at !== 514 + trig_odd) begin
         bad++; $display("FAIL b2b_xfer got=%0d bad=%0d abad=%0d done=%0d want=256/0/0/%0d",
                         wr_cnt, wr_bad, addr_bad, done_at, 514 + trig_odd); end
      @(negedge CPUCLK);
   endtask

   initial begin
      bus.CPU_ADDR = 16'h0000;
      bus.CPU_DI   = 8'h00;
      bus.CPU_WR   = 1'b0;
      bus.MEM_DI   = 8'h00;
      @(negedge CPUCLK);
      test_reset();
      test_ignore_other_write();
      test_even_start();
      test_odd_start();
      test_retrigger();
      test_reset_mid();
      test_page_ff();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
